imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, pipelined immediate generator for the next-generation RISC-V core. It extracts and extends every base-ISA immediate format (I, S, B, J, U), the CSR zero-extended immediate and shift amounts, for RV32 or RV64. It sits between decode and execute behind a valid/ready handshake, with a sideband tag carried alongside each result. It replaces the single-cycle combinational extender once decode and execute are split into separate pipeline stages.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- TAG_W, 5: width of the sideband tag carried with each result, e.g. rd or ROB index.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instr/immsrc/in_tag are valid.
- in_ready  out  1  block accepts the input this cycle.
- instr  in  32  full instruction word; bits [6:0] are ignored.
- immsrc  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR zimm), 110 SH (shamt), 111 reserved.
- in_tag  in  TAG_W  sideband; returned unchanged with the result.
- out_valid  out  1  imm/out_tag/out_err are valid.
- out_ready  in  1  consumer accepts the result.
- imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the transaction.
- out_err  out  1  immsrc was reserved, or SH on RV32 had instr[25]=1.

## Operation
- Format rules. s = instr[31], sign-replicated up to XLEN:
  - I: {s.., instr[31:20]}
  - S: {s.., instr[31:25], instr[11:7]}
  - B: {s.., instr[7], instr[30:25], instr[11:8], 0}
  - J: {s.., instr[19:12], instr[20], instr[30:21], 0}
  - U: {s.., instr[31:12], 12'b0}; on RV64 bit 31 is sign-extended.
  - Z: zero-extend instr[19:15].
  - SH: zero-extend instr[25:20] on RV64, instr[24:20] on RV32.
- RV32 SH with instr[25]=1: imm = shamt from instr[24:20], out_err=1.
- Reserved immsrc (111): imm=0, out_err=1.
- Two-stage elastic pipeline:
  - S1 registers instr, immsrc and tag.
  - S2 registers the computed imm, err and tag.
  - Extension logic sits between S1 and S2.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. in_ready is purely combinational from state and out_ready; it never depends on in_valid.
  - S2 loads from S1 when s2_adv; s2_valid <= s1_valid.
  - S1 loads from the input when s1_adv; s1_valid <= in_valid.
- A stalled S2 holds imm/out_tag/out_err stable until out_ready is sampled high.
- With out_ready held low, 2 transactions are buffered; in_ready drops after that.
- Simultaneous input and output transfer in the same cycle when both stages are full is legal; full throughput is maintained.
- No reordering, drop or duplication of transactions.

## Timing
- Latency: input accepted at edge N; out_valid is high after edge N+1.
- Throughput: 1 transaction per cycle when out_ready=1.
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, imm=0, out_tag=0, out_err=0, in_ready=1 once rst_n is high. In-flight transactions are discarded.
- The first acceptance is possible on the first rising edge after rst_n deasserts.
- S1/S2 data registers need no reset; output-facing S2 registers are reset to 0 so outputs are defined.

## Structure
- Shared package riscv_pkg holds:
  - immsrc encodings as named constants: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SH, IMM_RSV.
  - XLEN_32 and XLEN_64 constants.
- One sub-module, imm_ext_comb: purely combinational (instr, immsrc) -> (imm, err), parametrised by XLEN. It is instantiated between S1 and S2.
- The top level holds only pipeline registers and handshake logic.

## Test plan
- XLEN=32, I, instr 0xFFF00093 -> imm 0xFFFFFFFF two cycles later; S, 0xFE20AE23 -> 0xFFFFFFFC; B, 0xFE000CE3 -> 0xFFFFFFF8; Z, 0x000FD073 -> 0x0000001F.
- XLEN=64, U, instr 0x800002B7 -> imm 0xFFFFFFFF80000000; U 0x123452B7 -> 0x0000000012345000; SH 0x03F0D093 -> 0x3F, out_err=0.
- XLEN=32, immsrc 111 -> imm 0, out_err=1, tag echoed; SH with instr[25]=1 -> out_err=1.
- Back-to-back stream of 16 tagged transactions with random out_ready (50%) -> every tag emitted once, in order, with correct imm; outputs held stable while stalled; in_ready low only when both stages are full.
- Hold out_ready=0 with in_valid=1 -> exactly 2 accepted, then in_ready=0; release out_ready -> outputs at 1 per cycle.
- Assert rst_n low while both stages are full -> out_valid=0 and imm=0 immediately, without waiting for a clock edge; after release, no stale transaction appears.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: immediate-format selects and datapath widths.
package riscv_pkg;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_RSV = 3'b111;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational immediate extractor/extender for all base-ISA formats,
// CSR zimm and shift amounts; flags reserved selects and illegal RV32 shamts.
module imm_ext_comb
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    logic [31:0] raw_s;
    logic        sext_s;
    logic        unused_opcode_s;

    assign unused_opcode_s = ^instr[6:0];

    // Build a 32-bit field image, then widen it signed or unsigned to XLEN
    always_comb begin
        raw_s  = 32'd0;
        sext_s = 1'b0;
        err    = 1'b0;
        case (immsrc)
            IMM_I: begin
                raw_s  = {{20{instr[31]}}, instr[31:20]};
                sext_s = 1'b1;
            end
            IMM_S: begin
                raw_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                sext_s = 1'b1;
            end
            IMM_B: begin
                raw_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                sext_s = 1'b1;
            end
            IMM_J: begin
                raw_s  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                sext_s = 1'b1;
            end
            IMM_U: begin
                raw_s  = {instr[31:12], 12'd0};
                sext_s = 1'b1;
            end
            IMM_Z: begin
                raw_s = {27'd0, instr[19:15]};
            end
            IMM_SH: begin
                // RV32 still returns the 5-bit shamt but flags a set bit 25
                if (XLEN == XLEN_64) begin
                    raw_s = {26'd0, instr[25:20]};
                end else begin
                    raw_s = {27'd0, instr[24:20]};
                    err   = instr[25];
                end
            end
            IMM_RSV: begin
                err = 1'b1;
            end
            default: begin
                err = 1'b1;
            end
        endcase

        if (sext_s) begin
            imm = XLEN'($signed(raw_s));
        end else begin
            imm = XLEN'(raw_s);
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage elastic immediate generator: S1 captures the instruction, S2 holds
// the extended result; valid/ready on both sides with a pass-through tag.
module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    logic             s1_valid_r;
    logic [31:0]      s1_instr_r;
    logic [2:0]       s1_immsrc_r;
    logic [TAG_W-1:0] s1_tag_r;

    logic             s2_valid_r;
    logic [XLEN-1:0]  s2_imm_r;
    logic [TAG_W-1:0] s2_tag_r;
    logic             s2_err_r;

    logic             s1_adv_s;
    logic             s2_adv_s;
    logic [XLEN-1:0]  ext_imm_s;
    logic             ext_err_s;

    // A stage may advance when it is empty or its downstream is advancing
    assign s2_adv_s = !s2_valid_r || out_ready;
    assign s1_adv_s = !s1_valid_r || s2_adv_s;
    assign in_ready = s1_adv_s;

    imm_ext_comb #(
        .XLEN (XLEN)
    ) u_ext (
        .instr  (s1_instr_r),
        .immsrc (s1_immsrc_r),
        .imm    (ext_imm_s),
        .err    (ext_err_s)
    );

    // S1 occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
        end
    end

    // S1 payload; only meaningful while s1_valid_r is set
    always_ff @(posedge clk) begin
        if (s1_adv_s && in_valid) begin
            s1_instr_r  <= instr;
            s1_immsrc_r <= immsrc;
            s1_tag_r    <= in_tag;
        end
    end

    // S2 result registers drive the outputs directly, so they reset to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_imm_r   <= {XLEN{1'b0}};
            s2_tag_r   <= {TAG_W{1'b0}};
            s2_err_r   <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_imm_r <= ext_imm_s;
                s2_tag_r <= s1_tag_r;
                s2_err_r <= ext_err_s;
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign imm       = s2_imm_r;
    assign out_tag   = s2_tag_r;
    assign out_err   = s2_err_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: RV32 and RV64 instances share one input stream; a monitor
// pops hand-computed expectations on every output transfer.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  immsrc;
    logic [4:0]  in_tag;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic [4:0]  tag32;
    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;
    logic [4:0]  tag64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .imm(imm32), .out_tag(tag32), .out_err(err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .imm(imm64), .out_tag(tag64), .out_err(err64)
    );

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  src;
        logic [31:0] e32;
        logic        r32;
        logic [63:0] e64;
        logic        r64;
    } vec_t;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] e32;
        logic        r32;
        logic [63:0] e64;
        logic        r64;
    } exp_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];
    exp_t q [$];

    int   checks = 0;
    int   errors = 0;
    int   occ = 0;
    int   mode = 0;
    bit   mon_en = 1'b0;
    bit   hold_v = 1'b0;
    logic [31:0] h_imm32;
    logic [63:0] h_imm64;
    logic [4:0]  h_tag;
    logic        h_err32, h_err64;
    exp_t mon_e;
    logic mon_rdy;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_vec(input int idx, input logic [4:0] tag);
        q.push_back('{tag, vecs[idx].e32, vecs[idx].r32, vecs[idx].e64, vecs[idx].r64});
    endtask

    task automatic send(input int idx, input logic [4:0] tag);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        instr    = vecs[idx].ins;
        immsrc   = vecs[idx].src;
        in_tag   = tag;
        while (!in_ready32 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready32) begin
            checks++;
            errors++;
            $display("FAIL send_timeout tag=%0d", tag);
            in_valid = 1'b0;
        end else begin
            push_vec(idx, tag);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    // Consumer readiness: 0 always ready, 1 random, 2 stalled
    always @(negedge clk) begin
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (hold_v) begin
                chk("hold_valid", 64'(out_valid32), 64'd1);
                chk("hold_imm32", 64'(imm32), 64'(h_imm32));
                chk("hold_imm64", imm64, h_imm64);
                chk("hold_tag", 64'(tag32), 64'(h_tag));
                chk("hold_err", 64'({err32, err64}), 64'({h_err32, h_err64}));
            end
            mon_rdy = !(occ == 2 && !out_ready);
            chk("in_ready32", 64'(in_ready32), 64'(mon_rdy));
            chk("in_ready64", 64'(in_ready64), 64'(mon_rdy));
            chk("valid_pair", 64'(out_valid64), 64'(out_valid32));
            if (out_valid32 && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out got tag=%0d exp none", tag32);
                end else begin
                    mon_e = q.pop_front();
                    chk("tag32", 64'(tag32), 64'(mon_e.tag));
                    chk("imm32", 64'(imm32), 64'(mon_e.e32));
                    chk("err32", 64'(err32), 64'(mon_e.r32));
                    chk("tag64", 64'(tag64), 64'(mon_e.tag));
                    chk("imm64", imm64, mon_e.e64);
                    chk("err64", 64'(err64), 64'(mon_e.r64));
                end
            end
            hold_v  = out_valid32 && !out_ready;
            h_imm32 = imm32;
            h_imm64 = imm64;
            h_tag   = tag32;
            h_err32 = err32;
            h_err64 = err64;
            occ = occ + ((in_valid && in_ready32) ? 1 : 0) - ((out_valid32 && out_ready) ? 1 : 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;

        vecs[0]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{32'hFE20AE23, 3'b001, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[2]  = '{32'hFE000CE3, 3'b010, 32'hFFFFFFF8, 1'b0, 64'hFFFFFFFFFFFFFFF8, 1'b0};
        vecs[3]  = '{32'h000FD073, 3'b101, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
        vecs[4]  = '{32'h800002B7, 3'b100, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
        vecs[5]  = '{32'h123452B7, 3'b100, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
        vecs[6]  = '{32'h03F0D093, 3'b110, 32'h0000001F, 1'b1, 64'h000000000000003F, 1'b0};
        vecs[7]  = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1};
        vecs[8]  = '{32'h008000EF, 3'b011, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0};
        vecs[9]  = '{32'hFFDFF0EF, 3'b011, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[10] = '{32'h01F0D093, 3'b110, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
        vecs[11] = '{32'h7FF00013, 3'b000, 32'h000007FF, 1'b0, 64'h00000000000007FF, 1'b0};
        vecs[12] = '{32'h00208463, 3'b010, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = 32'd0;
        immsrc   = 3'd0;
        in_tag   = 5'd0;
        mode     = 0;

        #12;
        chk("rst_valid32", 64'(out_valid32), 64'd0);
        chk("rst_imm32", 64'(imm32), 64'd0);
        chk("rst_tag_err", 64'({tag32, err32, tag64, err64}), 64'd0);
        chk("rst_valid64", 64'(out_valid64), 64'd0);
        chk("rst_imm64", imm64, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready32), 64'd1);
        mon_en = 1'b1;

        // Latency: result visible one edge after the accepting edge
        send(0, 5'd1);
        chk("lat_s1_only", 64'(out_valid32), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_valid32", 64'(out_valid32), 64'd1);
        chk("lat_valid64", 64'(out_valid64), 64'd1);
        drain();

        for (int i = 0; i < NVEC; i++) begin
            send(i, 5'(i + 2));
        end
        drain();

        mode = 1;
        for (int i = 0; i < 16; i++) begin
            send(i % NVEC, 5'(i));
        end
        drain();

        // Stall the consumer: exactly two transactions fit
        mode = 2;
        @(negedge clk);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            in_valid = 1'b1;
            instr    = vecs[i].ins;
            immsrc   = vecs[i].src;
            in_tag   = 5'(20 + acc);
            if (in_ready32) begin
                push_vec(i, 5'(20 + acc));
                acc++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        chk("hold_accepted", 64'(acc), 64'd2);
        chk("hold_in_ready", 64'(in_ready32), 64'd0);
        mode = 0;
        n = 0;
        while (q.size() != 0 && n < 10) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("release_cycles", 64'(n), 64'd2);

        // Reset while both stages are full
        mode = 2;
        @(negedge clk);
        send(1, 5'd30);
        send(2, 5'd31);
        @(negedge clk);
        #3;
        chk("full_in_ready", 64'(in_ready32), 64'd0);
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid32", 64'(out_valid32), 64'd0);
        chk("arst_imm32", 64'(imm32), 64'd0);
        chk("arst_valid64", 64'(out_valid64), 64'd0);
        chk("arst_imm64", imm64, 64'd0);
        q.delete();
        occ    = 0;
        hold_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 0;
        mon_en = 1'b1;
        repeat (6) @(negedge clk);
        send(3, 5'd7);
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
